// File: rtl/lsu_ctrl.sv
// Load/store control stage: one request at a time, lane-shifted memory access.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module lsu_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_we,
    input  logic [2:0]        in_op,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wmask,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_rdata,
    output logic              out_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);

    state_t              state, state_n;
    logic                we_q;
    logic [2:0]          op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_inc;
    logic [31:0]         rdata_q;
    logic                err_q;
    logic                misal;
    logic                legal;
    logic                timeout_hit;
    logic [1:0]          off;
    logic [3:0]          mask;
    logic [31:0]         repl;
    logic [31:0]         lane;
    logic [31:0]         ext;

    always_comb begin
        misal = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        misal = (in_op[1:0] == 2'b01 && in_addr[0]) ||
                (in_op[1:0] == 2'b10 && in_addr[1:0] != 2'b00);
`endif
        legal = !(in_op == 3'b011 || in_op[2:1] == 2'b11) &&
                !(in_we && in_op[2]) && !misal;
    end

    assign cnt_inc     = cnt + CNT_W'(1);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                         (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    // Misaligned halves/words are forced onto their natural boundary.
    always_comb begin
        off  = 2'b00;
        mask = 4'b1111;
        repl = wdata_q;
        unique case (op_q[1:0])
            2'b00: begin
                off  = addr_q[1:0];
                mask = 4'b0001 << addr_q[1:0];
                repl = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                off  = {addr_q[1], 1'b0};
                mask = 4'b0011 << {addr_q[1], 1'b0};
                repl = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    assign lane = mem_rdata >> {off, 3'b000};

    always_comb begin
        ext = lane;
        unique case (op_q)
            3'b000:  ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  ext = {24'b0, lane[7:0]};
            3'b101:  ext = {16'b0, lane[15:0]};
            default: ext = lane;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (in_valid) state_n = legal ? REQ : RESP;
            REQ:     state_n = WAIT;
            WAIT:    if (mem_rvalid || timeout_hit) state_n = RESP;
            RESP:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            op_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    we_q    <= in_we;
                    op_q    <= in_op;
                    addr_q  <= in_addr;
                    wdata_q <= in_wdata;
                    rdata_q <= '0;
                    err_q   <= !legal;
                end
                REQ: cnt <= '0;
                WAIT: begin
                    cnt <= cnt_inc;
                    // An ack in the timeout cycle still counts as success.
                    if (mem_rvalid) begin
                        rdata_q <= we_q ? 32'b0 : ext;
                        err_q   <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                RESP: if (out_ready) begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign mem_req   = (state == REQ);
    assign mem_we    = mem_req && we_q;
    assign mem_addr  = mem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wmask = mem_we ? mask : 4'b0000;
    assign mem_wdata = mem_we ? repl : 32'b0;
    assign out_valid = (state == RESP);
    assign out_rdata = rdata_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized self-checking bench for lsu_ctrl against a byte-lane reference model.
// A second instance with TIMEOUT_CYCLES=4 shares the stimulus for timeout checks.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_we = 1'b0;
    logic [2:0]  in_op = 3'b000;
    logic [31:0] in_addr = '0;
    logic [31:0] in_wdata = '0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, mem_req, mem_we, out_valid, out_err;
    logic [31:0] mem_addr, mem_wdata, out_rdata;
    logic [3:0]  mem_wmask;

    logic        t_in_ready, t_mem_req, t_mem_we, t_out_valid, t_out_err;
    logic [31:0] t_mem_addr, t_mem_wdata, t_out_rdata;
    logic [3:0]  t_mem_wmask;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.TIMEOUT_CYCLES(255), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we),
        .in_op(in_op), .in_addr(in_addr), .in_wdata(in_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rdata(out_rdata), .out_err(out_err)
    );

    lsu_ctrl #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut_to (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(t_in_ready), .in_we(in_we),
        .in_op(in_op), .in_addr(in_addr), .in_wdata(in_wdata),
        .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr),
        .mem_wmask(t_mem_wmask), .mem_wdata(t_mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .out_valid(t_out_valid), .out_ready(out_ready),
        .out_rdata(t_out_rdata), .out_err(t_out_err)
    );

    // Reference model: access size in bytes, lane offset, and byte arithmetic.
    function automatic bit m_legal(input bit we, input logic [2:0] op,
                                   input logic [31:0] a);
        if (op == 3'b011 || op == 3'b110 || op == 3'b111) return 1'b0;
        if (we && (op == 3'b100 || op == 3'b101)) return 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (op[1:0] == 2'b01 && a[0]) return 1'b0;
        if (op[1:0] == 2'b10 && a[1:0] != 2'b00) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic int m_size(input logic [2:0] op);
        if (op[1:0] == 2'b00) return 1;
        if (op[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic int m_off(input logic [2:0] op, input logic [31:0] a);
        int s;
        s = m_size(op);
        return (int'(a % 4) / s) * s;
    endfunction

    function automatic logic [3:0] m_mask(input bit we, input logic [2:0] op,
                                          input logic [31:0] a);
        logic [7:0] m;
        if (!we) return 4'b0000;
        m = 8'((1 << m_size(op)) - 1) << m_off(op, a);
        return m[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] op,
                                            input logic [31:0] w);
        if (m_size(op) == 1) return {24'b0, w[7:0]} * 32'h0101_0101;
        if (m_size(op) == 2) return {16'b0, w[15:0]} * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] m_rdata(input bit we, input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] r);
        logic [31:0] v;
        logic [31:0] lim;
        int s;
        if (we) return 32'b0;
        s = m_size(op);
        v = r >> (8 * m_off(op, a));
        if (s == 4) return v;
        lim = (32'd1 << (8 * s)) - 32'd1;
        v = v & lim;
        if (!op[2] && v[8*s-1]) v = v | ~lim;
        return v;
    endfunction

    // Observations of the last transaction.
    bit          acc_ready, busy_ok, stable, post_ready, post_valid;
    int          req_cnt, lat, t_lat;
    logic        c_we, r_err, t_err;
    logic [31:0] c_addr, c_wdata, r_rdata, t_rdata;
    logic [3:0]  c_mask;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        mem_rvalid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at a negedge so calls can run back to back.
    task automatic do_txn(input bit we, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] w,
                          input logic [31:0] r, input int ack_delay,
                          input int ready_delay, input bit stray);
        bit done;
        bit seen_req;
        int wait_n;
        in_valid = 1'b1;
        in_we = we;
        in_op = op;
        in_addr = a;
        in_wdata = w;
        mem_rdata = r;
        acc_ready = in_ready;
        req_cnt = 0; lat = 0; t_lat = 0;
        busy_ok = 1'b1; stable = 1'b1;
        post_ready = 1'b0; post_valid = 1'b1;
        c_we = 1'b0; c_addr = '0; c_wdata = '0; c_mask = '0;
        r_rdata = '0; r_err = 1'b0; t_rdata = '0; t_err = 1'b0;
        done = 1'b0; seen_req = 1'b0; wait_n = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_we = 1'($urandom);
        in_op = 3'($urandom);
        in_addr = $urandom;
        in_wdata = $urandom;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clk);
            if (in_ready) busy_ok = 1'b0;
            if (t_out_valid && t_lat == 0) begin
                t_lat = c; t_err = t_out_err; t_rdata = t_out_rdata;
            end
            if (out_valid) begin
                done = 1'b1; lat = c;
                r_rdata = out_rdata; r_err = out_err;
                mem_rvalid = 1'b0;
            end else if (mem_req) begin
                req_cnt++;
                c_we = mem_we; c_addr = mem_addr;
                c_wdata = mem_wdata; c_mask = mem_wmask;
                seen_req = 1'b1;
                mem_rvalid = stray;
            end else begin
                mem_rvalid = seen_req && (wait_n == ack_delay);
                if (seen_req) wait_n++;
            end
        end
        mem_rvalid = 1'b0;
        if (done) begin
            out_ready = (ready_delay == 0);
            for (int h = 1; h <= ready_delay; h++) begin
                @(negedge clk);
                if (!out_valid || out_rdata !== r_rdata || out_err !== r_err)
                    stable = 1'b0;
                if (in_ready) busy_ok = 1'b0;
                if (mem_req) req_cnt++;
                out_ready = (h == ready_delay);
            end
            @(posedge clk);
            #1 out_ready = 1'b0;
            @(negedge clk);
            post_ready = in_ready;
            post_valid = out_valid;
        end
    endtask

    task automatic test_reset();
        do_reset();
        in_valid = 1'b1; in_we = 1'b1; in_op = 3'b010;
        in_addr = 32'h1234_5678; in_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else n_pass++;
        n_total++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req: got %b want 0", mem_req); else n_pass++;
        n_total++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we: got %b want 0", mem_we); else n_pass++;
        n_total++; if (mem_wmask !== 4'b0) $display("FAIL rst_wmask: got %b want 0000", mem_wmask); else n_pass++;
        n_total++; if (mem_addr !== 32'b0) $display("FAIL rst_mem_addr: got %h want 0", mem_addr); else n_pass++;
        n_total++; if (mem_wdata !== 32'b0) $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (out_err !== 1'b0) $display("FAIL rst_out_err: got %b want 0", out_err); else n_pass++;
        n_total++; if (out_rdata !== 32'b0) $display("FAIL rst_out_rdata: got %h want 0", out_rdata); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load_byte();
        do_reset();
        do_txn(1'b0, 3'b000, 32'h8000_0003, $urandom, 32'h80FF_1234, 0, 0, 1'b0);
        n_total++; if (lat !== 3) $display("FAIL lb_latency: got %0d want 3", lat); else n_pass++;
        n_total++; if (r_rdata !== 32'hFFFF_FF80) $display("FAIL lb_rdata: got %h want ffffff80", r_rdata); else n_pass++;
        n_total++; if (r_err !== 1'b0) $display("FAIL lb_err: got %b want 0", r_err); else n_pass++;
        n_total++; if (c_addr !== 32'h8000_0000) $display("FAIL lb_addr: got %h want 80000000", c_addr); else n_pass++;
        n_total++; if (c_mask !== 4'b0000 || c_we !== 1'b0) $display("FAIL lb_mask_we: got %b/%b want 0000/0", c_mask, c_we); else n_pass++;
    endtask

    task automatic test_store_half();
        do_reset();
        do_txn(1'b1, 3'b001, 32'h8000_0002, 32'h0000_BEEF, $urandom, 1, 0, 1'b0);
        n_total++; if (req_cnt !== 1) $display("FAIL sh_req_cycles: got %0d want 1", req_cnt); else n_pass++;
        n_total++; if (c_we !== 1'b1) $display("FAIL sh_we: got %b want 1", c_we); else n_pass++;
        n_total++; if (c_mask !== 4'b1100) $display("FAIL sh_mask: got %b want 1100", c_mask); else n_pass++;
        n_total++; if (c_wdata[31:16] !== 16'hBEEF) $display("FAIL sh_wdata: got %h want beef", c_wdata[31:16]); else n_pass++;
        n_total++; if (r_rdata !== 32'b0 || r_err !== 1'b0) $display("FAIL sh_resp: got %h/%b want 0/0", r_rdata, r_err); else n_pass++;
        n_total++; if (lat !== 4) $display("FAIL sh_latency: got %0d want 4", lat); else n_pass++;
    endtask

    task automatic test_backpressure();
        do_reset();
        do_txn(1'b0, 3'b101, 32'h0000_0010, $urandom, 32'hA5A5_8001, 5, 3, 1'b0);
        n_total++; if (r_rdata !== 32'h0000_8001) $display("FAIL bp_rdata: got %h want 00008001", r_rdata); else n_pass++;
        n_total++; if (lat !== 8) $display("FAIL bp_latency: got %0d want 8", lat); else n_pass++;
        n_total++; if (!stable) $display("FAIL bp_stable: got %b want 1", stable); else n_pass++;
        n_total++; if (!busy_ok) $display("FAIL bp_in_ready_low: got %b want 1", busy_ok); else n_pass++;
        n_total++; if (post_ready !== 1'b1 || post_valid !== 1'b0) $display("FAIL bp_release: got %b/%b want 1/0", post_ready, post_valid); else n_pass++;
    endtask

    task automatic test_illegal();
        do_reset();
        do_txn(1'b0, 3'b110, 32'h0000_0040, $urandom, $urandom, 0, 1, 1'b0);
        n_total++; if (r_err !== 1'b1 || r_rdata !== 32'b0) $display("FAIL ill_op_resp: got %b/%h want 1/0", r_err, r_rdata); else n_pass++;
        n_total++; if (req_cnt !== 0 || lat !== 1) $display("FAIL ill_op_noreq: got req=%0d lat=%0d want 0/1", req_cnt, lat); else n_pass++;
        do_txn(1'b1, 3'b100, 32'h0000_0041, $urandom, $urandom, 0, 0, 1'b0);
        n_total++; if (acc_ready !== 1'b1) $display("FAIL ill_b2b_ready: got %b want 1", acc_ready); else n_pass++;
        n_total++; if (r_err !== 1'b1 || req_cnt !== 0) $display("FAIL ill_sbu: got err=%b req=%0d want 1/0", r_err, req_cnt); else n_pass++;
    endtask

    task automatic test_timeout();
        logic [31:0] r;
        do_reset();
        do_txn(1'b0, 3'b010, 32'h0000_0020, $urandom, $urandom, 100, 0, 1'b0);
        n_total++; if (t_lat !== 6) $display("FAIL to_latency: got %0d want 6", t_lat); else n_pass++;
        n_total++; if (t_err !== 1'b1 || t_rdata !== 32'b0) $display("FAIL to_resp: got %b/%h want 1/0", t_err, t_rdata); else n_pass++;
        n_total++; if (lat !== 0) $display("FAIL to_long_no_resp: got %0d want 0", lat); else n_pass++;
        do_reset();
        r = $urandom;
        do_txn(1'b0, 3'b010, 32'h0000_0024, $urandom, r, 3, 0, 1'b0);
        n_total++; if (t_lat !== 6 || t_err !== 1'b0) $display("FAIL to_ack_wins: got lat=%0d err=%b want 6/0", t_lat, t_err); else n_pass++;
        n_total++; if (t_rdata !== r) $display("FAIL to_ack_data: got %h want %h", t_rdata, r); else n_pass++;
    endtask

    task automatic test_misaligned();
        logic [31:0] r;
        do_reset();
        r = $urandom;
        do_txn(1'b0, 3'b010, 32'h8000_0102, $urandom, r, 0, 0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        n_total++; if (r_err !== 1'b1 || req_cnt !== 0) $display("FAIL mis_word: got err=%b req=%0d want 1/0", r_err, req_cnt); else n_pass++;
`else
        n_total++; if (c_addr !== 32'h8000_0100 || r_rdata !== r || r_err !== 1'b0) $display("FAIL mis_word: got %h/%h/%b want 80000100/%h/0", c_addr, r_rdata, r_err, r); else n_pass++;
`endif
        do_txn(1'b0, 3'b001, 32'h8000_0103, $urandom, r, 1, 0, 1'b0);
        n_total++; if (r_rdata !== m_rdata(1'b0, 3'b001, 32'h8000_0103, r) || r_err !== !m_legal(1'b0, 3'b001, 32'h8000_0103)) $display("FAIL mis_half: got %h/%b", r_rdata, r_err); else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        bit quiet;
        do_reset();
        in_valid = 1'b1; in_we = 1'b0; in_op = 3'b010; in_addr = 32'h0000_0030;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL rmw_async: got %b/%b want 1/0", in_ready, out_valid); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        mem_rvalid = 1'b1;
        quiet = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || mem_req !== 1'b0) quiet = 1'b0;
        end
        mem_rvalid = 1'b0;
        n_total++; if (!quiet) $display("FAIL rmw_stray_ack: got %b want 1", quiet); else n_pass++;
        do_txn(1'b0, 3'b100, 32'h0000_0031, $urandom, 32'h0000_C300, 0, 0, 1'b0);
        n_total++; if (r_rdata !== 32'h0000_00C3 || r_err !== 1'b0 || lat !== 3) $display("FAIL rmw_next: got %h/%b/%0d want 000000c3/0/3", r_rdata, r_err, lat); else n_pass++;
    endtask

    task automatic test_random();
        bit we, ok;
        logic [2:0] op;
        logic [31:0] a, w, r;
        int ad, rd;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom);
            op = 3'($urandom);
            a = $urandom;
            w = $urandom;
            r = $urandom;
            ad = $urandom_range(0, 6);
            rd = $urandom_range(0, 3);
            do_txn(we, op, a, w, r, ad, rd, 1'($urandom));
            ok = m_legal(we, op, a);
            n_total++;
            if (r_err !== !ok || r_rdata !== (ok ? m_rdata(we, op, a, r) : 32'b0))
                $display("FAIL rand_resp[%0d]: got %h/%b want %h/%b", i, r_rdata, r_err, ok ? m_rdata(we, op, a, r) : 32'b0, !ok);
            else n_pass++;
            n_total++;
            if (lat !== (ok ? 3 + ad : 1) || req_cnt !== (ok ? 1 : 0))
                $display("FAIL rand_timing[%0d]: got lat=%0d req=%0d want %0d/%0d", i, lat, req_cnt, ok ? 3 + ad : 1, ok ? 1 : 0);
            else n_pass++;
            if (ok) begin
                n_total++;
                if (c_addr !== {a[31:2], 2'b00} || c_we !== we || c_mask !== m_mask(we, op, a) || (we && c_wdata !== m_wdata(op, w)))
                    $display("FAIL rand_mem[%0d]: got %h/%b/%b/%h want %h/%b/%b/%h", i, c_addr, c_we, c_mask, c_wdata, {a[31:2], 2'b00}, we, m_mask(we, op, a), m_wdata(op, w));
                else n_pass++;
            end
            n_total++;
            if (!stable || !busy_ok || !acc_ready || !post_ready || post_valid)
                $display("FAIL rand_hs[%0d]: got st=%b busy=%b acc=%b post=%b/%b want 1/1/1/1/0", i, stable, busy_ok, acc_ready, post_ready, post_valid);
            else n_pass++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_byte();
        test_store_half();
        test_backpressure();
        test_illegal();
        test_timeout();
        test_misaligned();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
